// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch with one outstanding read and a DEPTH-entry prefetch queue.
// Define FETCH_PERF_EN to add saturating fetch_count/drop_count outputs.
module fetch_unit #(
    parameter int          DEPTH    = 2,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        instr_valid,
    output logic [15:0] instr,
    output logic [15:0] instr_pc,
`ifdef FETCH_PERF_EN
    output logic [15:0] fetch_count,
    output logic [15:0] drop_count,
`endif
    input  logic        instr_ready
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
    typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;
    state_t        state, state_nxt;
    logic [15:0]   fetch_pc, drop_addr;
    logic [15:0]   q_instr [DEPTH];
    logic [15:0]   q_pc [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [PW:0]   count, cnt_nxt;
    logic          push, pop, room;
    assign mem_req     = state != IDLE;
    assign mem_addr    = state == DROP ? drop_addr : fetch_pc;
    assign instr_valid = count != '0;
    assign instr       = instr_valid ? q_instr[rd_ptr] : 16'hF000;
    assign instr_pc    = instr_valid ? q_pc[rd_ptr] : 16'h0000;
    // A redirect restarts fetch at once unless the old read is still pending.
    always_comb begin
        pop       = instr_valid & instr_ready & ~redirect;
        push      = (state == REQ) & mem_ack & ~redirect;
        cnt_nxt   = redirect ? '0 : count + (PW+1)'(push) - (PW+1)'(pop);
        room      = cnt_nxt != FULL;
        state_nxt = state;
        if (redirect)
            state_nxt = (state != IDLE && !mem_ack) ? DROP : REQ;
        else if (state == IDLE)
            state_nxt = room ? REQ : IDLE;
        else if (mem_ack)
            state_nxt = (state == REQ && room) ? REQ : IDLE;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            fetch_pc  <= RESET_PC;
            drop_addr <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
        end else begin
            state <= state_nxt;
            count <= cnt_nxt;
            if (redirect) begin
                fetch_pc <= redirect_pc & 16'hFFFE;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                if (state == REQ)
                    drop_addr <= fetch_pc;
            end else begin
                if (push) begin
                    fetch_pc <= fetch_pc + 16'd2;
                    wr_ptr   <= wr_ptr + PW'(1);
                end
                if (pop)
                    rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end
    always_ff @(posedge clk) begin
        if (push) begin
            q_instr[wr_ptr] <= mem_rdata;
            q_pc[wr_ptr]    <= fetch_pc;
        end
    end
`ifdef FETCH_PERF_EN
    logic drop_ack;
    assign drop_ack = mem_ack & ((state == DROP) | (redirect & (state == REQ)));
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_count <= '0;
            drop_count  <= '0;
        end else begin
            if (push && fetch_count != 16'hFFFF)
                fetch_count <= fetch_count + 16'd1;
            if (drop_ack && drop_count != 16'hFFFF)
                drop_count <= drop_count + 16'd1;
        end
    end
`endif
endmodule
